// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: the registered operation
// state that records what the FIFO did on the previous clock edge, plus
// small decode helpers used by the top level's output logic.
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5,
    RD_WR    = 3'd6
  } fifo_state_e;

  // True when the recorded operation stored a word.
  function automatic logic stateWroteWord(input fifo_state_e s);
    return (s == WRITE) || (s == RD_WR);
  endfunction

  // True when the recorded operation delivered a word to dout.
  function automatic logic stateReadWord(input fifo_state_e s);
    return (s == READ) || (s == RD_WR);
  endfunction

endpackage

// File: rtl/fifo_param_next.sv
// Combinational decode for the FIFO: chooses the operation for this cycle
// from the request lines and the occupancy flags, then produces the next
// pointer and count values plus the memory write/read enables.
module fifo_param_next
  import fifo_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic        wrEn_i,
  input  logic        rdEn_i,
  input  logic        full_i,
  input  logic        empty_i,
  input  logic [AW-1:0] head_i,
  input  logic [AW-1:0] tail_i,
  input  logic [AW:0]   count_i,
  output fifo_state_e state_o,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [AW:0]   count_o,
  output logic        we_o,
  output logic        re_o,
  output logic        rdErrBoth_o
);

  localparam int CW = AW + 1;

  // Pick the operation; a simultaneous request on a full FIFO succeeds on
  // both sides because the read frees the slot the write fills, while on an
  // empty FIFO only the write can be honoured.
  always_comb begin
    state_o     = NO_OP;
    we_o        = 1'b0;
    re_o        = 1'b0;
    rdErrBoth_o = 1'b0;
    unique case ({wrEn_i, rdEn_i})
      2'b00: begin
        state_o = NO_OP;
      end
      2'b10: begin
        if (full_i) begin
          state_o = WR_ERROR;
        end else begin
          state_o = WRITE;
          we_o    = 1'b1;
        end
      end
      2'b01: begin
        if (empty_i) begin
          state_o = RD_ERROR;
        end else begin
          state_o = READ;
          re_o    = 1'b1;
        end
      end
      default: begin
        if (empty_i) begin
          state_o     = WRITE;
          we_o        = 1'b1;
          rdErrBoth_o = 1'b1;
        end else begin
          state_o = RD_WR;
          we_o    = 1'b1;
          re_o    = 1'b1;
        end
      end
    endcase
  end

  // Advance pointers (power-of-two depth, so they wrap naturally) and
  // update occupancy; a paired read+write leaves the count unchanged.
  always_comb begin
    head_o  = re_o ? head_i + AW'(1) : head_i;
    tail_o  = we_o ? tail_i + AW'(1) : tail_i;
    count_o = count_i + CW'(we_o) - CW'(re_o);
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data and one-cycle
// ack/error pulses for every write and read request.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty
// threshold outputs and the AF_LEVEL/AE_LEVEL parameters that drive them.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_ack,
  output logic                     wr_err,
  output logic                     rd_ack,
  output logic                     rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                     almost_full,
  output logic                     almost_empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_state_e           state_q, state_d;
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rdErrBoth_q, rdErrBoth_d;
  logic                  we, re;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign data_count = count_q;
  assign dout       = dout_q;

  fifo_param_next #(
    .AW(AW)
  ) u_next (
    .wrEn_i      (wr_en),
    .rdEn_i      (rd_en),
    .full_i      (full),
    .empty_i     (empty),
    .head_i      (head_q),
    .tail_i      (tail_q),
    .count_i     (count_q),
    .state_o     (state_d),
    .head_o      (head_d),
    .tail_o      (tail_d),
    .count_o     (count_d),
    .we_o        (we),
    .re_o        (re),
    .rdErrBoth_o (rdErrBoth_d)
  );

  // State, pointer and occupancy registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rdErrBoth_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rdErrBoth_q <= rdErrBoth_d;
    end
  end

  // Storage array is deliberately left unreset; only occupied slots are read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[tail_q] <= din;
    end
  end

  // Read data register; on a full FIFO with a paired write the head and
  // tail slots coincide, and the old word is returned because the array
  // update lands after this read samples it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (re) begin
      dout_q <= mem[head_q];
    end
  end

  // Ack/error pulses decoded from the registered operation state.
  always_comb begin
    wr_ack = stateWroteWord(state_q);
    rd_ack = stateReadWord(state_q);
    wr_err = (state_q == WR_ERROR);
    rd_err = (state_q == RD_ERROR) || rdErrBoth_q;
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // Threshold flags compare the registered occupancy against the levels.
  always_comb begin
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
  end
`endif

  // Occupancy must stay within the physical depth.
  assert property (@(posedge clk) disable iff (!reset_n) count_q <= CW'(DEPTH))
    else $error("fifo_param: occupancy exceeded depth");

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (32 bits x 8 entries). A queue model
// holds the words the FIFO should contain; each read pops the expected word
// and it is compared with dout one cycle after rd_en is sampled.
module tb_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          resetN;
  logic          wrEn;
  logic          rdEn;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [AW:0]   dataCount;
  logic          full, empty;
  logic          wrAck, wrErr, rdAck, rdErr;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almostFull, almostEmpty;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sbQueue [$];
  logic [DW-1:0] modelDout;

  fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (resetN),
    .wr_en       (wrEn),
    .din         (din),
    .rd_en       (rdEn),
    .dout        (dout),
    .data_count  (dataCount),
    .full        (full),
    .empty       (empty),
    .wr_ack      (wrAck),
    .wr_err      (wrErr),
    .rd_ack      (rdAck),
    .rd_err      (rdErr)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full (almostFull),
    .almost_empty(almostEmpty)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs that must read as their reset values.
  task automatic checkResetState();
    checkOutput("rst_count", 32'(dataCount), 32'd0);
    checkOutput("rst_fullEmpty", {30'd0, full, empty}, 32'd1);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_ackErr", {28'd0, wrAck, wrErr, rdAck, rdErr}, 32'd0);
  endtask

  // Drive one cycle of requests, update the queue model, then check the
  // outputs produced by that clock edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
    logic expWe, expRe, expWrErr, expRdErr;
    int   occ;
    wrEn = w;
    rdEn = r;
    din  = d;
    occ      = sbQueue.size();
    expRe    = r && (occ > 0);
    expWe    = w && ((occ < DEPTH) || r);
    expWrErr = w && !expWe;
    expRdErr = r && !expRe;
    if (expRe) modelDout = sbQueue.pop_front();
    if (expWe) sbQueue.push_back(d);
    occ = sbQueue.size();
    @(posedge clk);
    #1;
    checkOutput("ackErr", {28'd0, wrAck, wrErr, rdAck, rdErr},
                {28'd0, expWe, expWrErr, expRe, expRdErr});
    checkOutput("count", 32'(dataCount), 32'(occ));
    checkOutput("fullEmpty", {30'd0, full, empty},
                {30'd0, (occ == DEPTH), (occ == 0)});
    checkOutput("dout", dout, modelDout);
`ifdef FIFO_ALMOST_FLAGS_EN
    checkOutput("almost", {30'd0, almostFull, almostEmpty},
                {30'd0, (occ >= DEPTH - 2), (occ <= 2)});
`endif
  endtask

  initial begin
    resetN    = 1'b0;
    wrEn      = 1'b0;
    rdEn      = 1'b0;
    din       = '0;
    modelDout = '0;

    #2;
    checkResetState();
    @(negedge clk);
    resetN = 1'b1;

    $display("[TB] mid-stream reset after three writes");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i));
    wrEn = 1'b1;
    din  = 32'h77;
    #3;
    resetN = 1'b0;
    sbQueue.delete();
    modelDout = '0;
    #1;
    checkResetState();
    wrEn = 1'b0;
    #2;
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);

    $display("[TB] fill, overflow, drain, underflow");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 32'(i));
    applyStimulus(1'b1, 1'b0, 32'h9);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("underflow_dout", dout, 32'h8);

    $display("[TB] paired read+write on full and empty");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 32'(i));
    applyStimulus(1'b1, 1'b1, 32'hA);
    checkOutput("fullBoth_dout", dout, 32'h1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0);
    checkOutput("fullBoth_last", dout, 32'hA);
    applyStimulus(1'b1, 1'b1, 32'h5);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("emptyBoth_read", dout, 32'h5);

    $display("[TB] interleaved traffic across pointer wrap");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sbQueue.size() > 0) applyStimulus(1'b0, 1'b1, '0);
    end
    applyStimulus(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
